// File: rtl/io_writeback_arbiter.sv
// io_writeback_arbiter
// Shares the CPU's single IO writeback channel between NUMPORTS peripherals.
// A combinational arbiter picks one requester per cycle and a one-entry
// output buffer drives the CPU WritebackREQ/ACK handshake. Beats without a
// register response are accepted and counted in a saturating DropCount.
// Optional build macro: IOWB_ARB_FIXEDPRIORITY_EN (search always starts at
// port 0 instead of the round-robin pointer).
module io_writeback_arbiter #(
    parameter int NUMPORTS      = 4,
    parameter int DATABITWIDTH  = 16,
    parameter int DROPCOUNTBITS = 8
) (
    input  logic                                clk,
    input  logic                                clk_en,
    input  logic                                sync_rst,
    input  logic [NUMPORTS-1:0]                 Port_REQ,
    output logic [NUMPORTS-1:0]                 Port_ACK,
    input  logic [NUMPORTS-1:0]                 Port_RegResponseFlag,
    input  logic [4*NUMPORTS-1:0]               Port_DestReg,
    input  logic [DATABITWIDTH*NUMPORTS-1:0]    Port_Data,
    output logic                                WritebackREQ,
    input  logic                                WritebackACK,
    output logic [3:0]                          WritebackDestReg,
    output logic [DATABITWIDTH-1:0]             WritebackDataOut,
    output logic [$clog2(NUMPORTS)-1:0]         WritebackSource,
    output logic [DROPCOUNTBITS-1:0]            DropCount
);

    localparam int SRCW = $clog2(NUMPORTS);

    logic                     r_full;
    logic [3:0]               r_dest;
    logic [DATABITWIDTH-1:0]  r_data;
    logic [SRCW-1:0]          r_src;
    logic [DROPCOUNTBITS-1:0] r_drop;

    logic                     w_free;
    logic                     w_found;
    logic                     w_xfer;
    logic                     w_load;
    logic                     w_drop;
    logic [SRCW-1:0]          w_winner;
    logic [SRCW-1:0]          w_base;
    logic [SRCW-1:0]          w_ptr_next;
    logic                     w_win_flag;
    logic [3:0]               w_win_dest;
    logic [DATABITWIDTH-1:0]  w_win_data;

`ifdef IOWB_ARB_FIXEDPRIORITY_EN
    assign w_base = '0;
`else
    logic [SRCW-1:0] r_ptr;
    assign w_base = r_ptr;
`endif

    // Capacity exists when empty, or when the held beat drains this cycle.
    assign w_free = !r_full || WritebackACK;

    // Circular search from w_base; first eligible requester wins.
    always_comb begin
        logic [SRCW:0]   v_sum;
        logic [SRCW-1:0] v_idx;
        w_found  = 1'b0;
        w_winner = '0;
        v_sum    = '0;
        v_idx    = '0;
        for (int k = 0; k < NUMPORTS; k++) begin
            v_sum = {1'b0, w_base} + (SRCW+1)'(k);
            if (v_sum >= (SRCW+1)'(NUMPORTS)) begin
                v_sum = v_sum - (SRCW+1)'(NUMPORTS);
            end
            v_idx = v_sum[SRCW-1:0];
            if (!w_found && Port_REQ[v_idx] &&
                (!Port_RegResponseFlag[v_idx] || w_free)) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end
        end
    end

    // Select the winning port's beat fields.
    always_comb begin
        w_win_flag = 1'b0;
        w_win_dest = '0;
        w_win_data = '0;
        for (int p = 0; p < NUMPORTS; p++) begin
            if (w_winner == SRCW'(p)) begin
                w_win_flag = Port_RegResponseFlag[p];
                w_win_dest = Port_DestReg[4*p +: 4];
                w_win_data = Port_Data[DATABITWIDTH*p +: DATABITWIDTH];
            end
        end
    end

    assign w_xfer     = w_found && clk_en && !sync_rst;
    assign w_load     = w_xfer && w_win_flag;
    assign w_drop     = w_xfer && !w_win_flag;
    assign w_ptr_next = (w_winner == SRCW'(NUMPORTS-1)) ? '0 : w_winner + SRCW'(1);

    // Grant is one-hot on the winner, suppressed by reset and clock enable.
    always_comb begin
        Port_ACK = '0;
        if (w_xfer) begin
            Port_ACK[w_winner] = 1'b1;
        end
    end

    // Output buffer: load has priority over drain (drain-and-refill).
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_full <= 1'b0;
            r_dest <= '0;
            r_data <= '0;
            r_src  <= '0;
        end else if (clk_en) begin
            if (w_load) begin
                r_full <= 1'b1;
                r_dest <= w_win_dest;
                r_data <= w_win_data;
                r_src  <= w_winner;
            end else if (r_full && WritebackACK) begin
                r_full <= 1'b0;
            end
        end
    end

    // Saturating count of discarded beats.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_drop <= '0;
        end else if (clk_en && w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + DROPCOUNTBITS'(1);
        end
    end

`ifndef IOWB_ARB_FIXEDPRIORITY_EN
    // Round-robin pointer moves past every winner, loaded or discarded.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_next;
        end
    end
`endif

    assign WritebackREQ     = r_full;
    assign WritebackDestReg = r_dest;
    assign WritebackDataOut = r_data;
    assign WritebackSource  = r_src;
    assign DropCount        = r_drop;

endmodule
